// File: rtl/axis_pingpong_packetizer.sv
// axis_pingpong_packetizer
// Two-bank AXI4-Stream packetizer. Incoming samples fill one bank while the
// other drains to the master. Each completed bank raises a fixed-length
// interrupt pulse. Samples offered while both banks are full are dropped and
// flagged on a sticky overflow bit.
// Optional build macro: AXIS_PKT_HDR_EN prefixes every packet with a
// DATA_WIDTH-bit sequence-number header word.
module axis_pingpong_packetizer #(
  parameter int DATA_WIDTH = 16,
  parameter int SMPLS      = 30,
  parameter int INTR_CLKS  = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  m_axis_interrupt,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int IW = (SMPLS > 1) ? $clog2(SMPLS) : 1;
  localparam int CW = $clog2(INTR_CLKS + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(SMPLS - 1);
  localparam logic [CW-1:0] INTR_LOAD = CW'(INTR_CLKS);

`ifdef AXIS_PKT_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} rd_state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_DATA} rd_state_t;
`endif

  logic [DATA_WIDTH-1:0] mem [2][SMPLS];
  logic [1:0]            bank_full;
  logic [1:0]            bank_full_nxt;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         rd_idx_inc;
  logic [CW-1:0]         intr_cnt;
  rd_state_t             rd_state;
  logic                  accept;
  logic                  wr_done;
  logic                  rd_hs;
  logic                  rd_done;
`ifdef AXIS_PKT_HDR_EN
  logic [DATA_WIDTH-1:0] pkt_seq;
`endif

  assign s_axis_tready = ~bank_full[wr_bank];
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign wr_done       = accept & (wr_idx == LAST_IDX);
  assign rd_hs         = m_axis_tvalid & m_axis_tready;
  assign rd_done       = (rd_state == S_DATA) & rd_hs & m_axis_tlast;
  assign rd_idx_inc    = rd_idx + IW'(1);

  // Sample storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge aclk) begin
    if (accept) mem[wr_bank][wr_idx] <= s_axis_tdata;
  end

  // Writer sets the bank it just filled, reader clears the bank it drained;
  // they never target the same bank in one cycle.
  always_comb begin
    bank_full_nxt = bank_full;
    if (rd_done) bank_full_nxt[rd_bank] = 1'b0;
    if (wr_done) bank_full_nxt[wr_bank] = 1'b1;
  end

  // Write pointer, bank selection and bank-full flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
    end else begin
      bank_full <= bank_full_nxt;
      if (accept) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
    end
  end

  // Interrupt pulse timer; a new completion reloads it so pulses merge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      intr_cnt         <= '0;
      m_axis_interrupt <= 1'b0;
    end else if (wr_done) begin
      intr_cnt         <= INTR_LOAD;
      m_axis_interrupt <= 1'b1;
    end else if (intr_cnt != '0) begin
      intr_cnt         <= intr_cnt - CW'(1);
      m_axis_interrupt <= (intr_cnt != CW'(1));
    end else begin
      m_axis_interrupt <= 1'b0;
    end
  end

  // Sticky overflow; a new overflow wins over a same-cycle clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovf <= 1'b0;
    end else if (s_axis_tvalid & ~s_axis_tready) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Read FSM: drains one full bank per packet with registered stream outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state      <= S_IDLE;
      rd_bank       <= 1'b0;
      rd_idx        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
`ifdef AXIS_PKT_HDR_EN
      pkt_seq       <= '0;
`endif
    end else begin
      case (rd_state)
        S_IDLE: begin
          if (bank_full[rd_bank]) begin
            m_axis_tvalid <= 1'b1;
`ifdef AXIS_PKT_HDR_EN
            m_axis_tdata  <= pkt_seq;
            m_axis_tlast  <= 1'b0;
            rd_state      <= S_HDR;
`else
            m_axis_tdata  <= mem[rd_bank][0];
            m_axis_tlast  <= (LAST_IDX == '0);
            rd_state      <= S_DATA;
`endif
          end
        end
`ifdef AXIS_PKT_HDR_EN
        S_HDR: begin
          if (rd_hs) begin
            m_axis_tdata <= mem[rd_bank][0];
            m_axis_tlast <= (LAST_IDX == '0);
            rd_state     <= S_DATA;
          end
        end
`endif
        S_DATA: begin
          if (rd_hs) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              rd_idx        <= '0;
              rd_bank       <= ~rd_bank;
              rd_state      <= S_IDLE;
`ifdef AXIS_PKT_HDR_EN
              pkt_seq       <= pkt_seq + DATA_WIDTH'(1);
`endif
            end else begin
              rd_idx       <= rd_idx_inc;
              m_axis_tdata <= mem[rd_bank][rd_idx_inc];
              m_axis_tlast <= (rd_idx_inc == LAST_IDX);
            end
          end
        end
        default: rd_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pingpong_packetizer.sv
// Self-checking bench for axis_pingpong_packetizer (SMPLS=4, INTR_CLKS=32).
// Expected output words are queued as samples are accepted and compared as
// the master side handshakes them.
module tb_axis_pingpong_packetizer;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int IC = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic          m_intr;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW:0]   sb_q[$];
  logic [DW:0]   sb_e;
  int            pkt_pos = 0;
  logic [DW-1:0] seq_exp = '0;
  logic          tog = 1'b0;
  logic          win = 1'b0;
  int            win_low = 0;
  logic          ps = 1'b0;
  logic [DW-1:0] pd = '0;
  logic          pl = 1'b0;

  axis_pingpong_packetizer #(.DATA_WIDTH(DW), .SMPLS(NS), .INTR_CLKS(IC)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready), .m_axis_interrupt(m_intr),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Offer one sample, wait for acceptance, queue the expected output word(s).
  task automatic send(input logic [DW-1:0] d);
    int w = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    @(negedge aclk);
    while (!s_tready && w < 200) begin
      @(negedge aclk);
      w++;
    end
    if (!s_tready) begin
      check_val("send_timeout", 32'(s_tready), 1);
    end else begin
`ifdef AXIS_PKT_HDR_EN
      if (pkt_pos == 0) begin
        sb_q.push_back({1'b0, seq_exp});
        seq_exp++;
      end
`endif
      sb_q.push_back({(pkt_pos == NS - 1), d});
      pkt_pos = (pkt_pos + 1) % NS;
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(negedge aclk);
      w++;
    end
    check_val("drain", sb_q.size(), 0);
  endtask

  // Master-ready toggling for the back-pressure pattern test.
  always @(posedge aclk) begin
    if (tog) begin
      #1;
      m_tready = ~m_tready;
    end
  end

  // Output monitor: scoreboard compare, AXIS hold rule, interrupt gap watch.
  always @(negedge aclk) begin
    if (!aresetn) begin
      ps = 1'b0;
    end else begin
      if (ps) begin
        check_val("hold_valid", 32'(m_tvalid), 1);
        check_val("hold_data", 32'(m_tdata), 32'(pd));
        check_val("hold_last", 32'(m_tlast), 32'(pl));
      end
      if (m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_word", sb_q.size(), 1);
        end else begin
          sb_e = sb_q.pop_front();
          check_val("out_data", 32'(m_tdata), 32'(sb_e[DW-1:0]));
          check_val("out_last", 32'(m_tlast), 32'(sb_e[DW]));
        end
      end
      ps = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      if (win && !m_intr) win_low++;
    end
  end

  initial begin
    int n;
    int found;

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    check_val("rst_s_tready", 32'(s_tready), 1);
    check_val("rst_m_tvalid", 32'(m_tvalid), 0);
    check_val("rst_m_tdata", 32'(m_tdata), 0);
    check_val("rst_m_tlast", 32'(m_tlast), 0);
    check_val("rst_intr", 32'(m_intr), 0);
    check_val("rst_ovf", 32'(ovf), 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // Basic packet, latency and interrupt length
    for (int i = 1; i <= 4; i++) send(DW'(i));
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      if (i == 0) begin
        check_val("lat_tvalid_t1", 32'(m_tvalid), 0);
        check_val("lat_intr_t1", 32'(m_intr), 1);
      end
      if (i == 1) check_val("lat_tvalid_t2", 32'(m_tvalid), 1);
      if (m_intr) n++;
    end
    check_val("intr_len", n, IC);
    wait_drain();

    // Back-pressure pattern on master ready
    @(posedge aclk);
    #1;
    tog = 1'b1;
    for (int i = 1; i <= 4; i++) send(DW'(i));
    wait_drain();
    tog = 1'b0;
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    repeat (40) @(posedge aclk);
    #1;

    // Both banks full, overflow, ovf clear, drain ordering
    m_tready = 1'b0;
    for (int i = 1; i <= 8; i++) send(DW'(16'h10 + i));
    @(negedge aclk);
    check_val("full_s_tready", 32'(s_tready), 0);
    @(posedge aclk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = 16'h0099;
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    @(negedge aclk);
    check_val("ovf_set", 32'(ovf), 1);
    @(posedge aclk);
    #1;
    ovf_clr = 1'b1;
    @(posedge aclk);
    #1;
    ovf_clr = 1'b0;
    @(negedge aclk);
    check_val("ovf_clr", 32'(ovf), 0);
    @(posedge aclk);
    #1;
    ovf_clr  = 1'b1;
    s_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    ovf_clr  = 1'b0;
    s_tvalid = 1'b0;
    @(negedge aclk);
    check_val("ovf_set_wins", 32'(ovf), 1);
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge aclk);
      if (m_tvalid && m_tready && m_tlast) begin
        found = 1;
        check_val("tlast_s_tready", 32'(s_tready), 0);
      end
    end
    check_val("tlast_seen", found, 1);
    @(negedge aclk);
    check_val("free_s_tready", 32'(s_tready), 1);
    check_val("gap_tvalid", 32'(m_tvalid), 0);
    @(negedge aclk);
    check_val("next_tvalid", 32'(m_tvalid), 1);
    wait_drain();
    repeat (40) @(posedge aclk);
    #1;

    // Interrupt reload while the pulse is running
    for (int i = 1; i <= 4; i++) send(DW'(16'h20 + i));
    win_low = 0;
    win = 1'b1;
    repeat (18) @(posedge aclk);
    #1;
    for (int i = 1; i <= 4; i++) send(DW'(16'h30 + i));
    win = 1'b0;
    check_val("intr_no_gap", win_low, 0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      if (m_intr) n++;
    end
    check_val("intr_reload_len", n, IC);
    wait_drain();

    // Asynchronous reset mid-packet and mid-output
    @(posedge aclk);
    #1;
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send(DW'(16'hA0 + i));
    send(16'hB1);
    send(16'hB2);
    repeat (3) @(posedge aclk);
    #1;
    m_tready = 1'b1;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    aresetn = 1'b0;
    #1;
    check_val("arst_s_tready", 32'(s_tready), 1);
    check_val("arst_m_tvalid", 32'(m_tvalid), 0);
    check_val("arst_m_tdata", 32'(m_tdata), 0);
    check_val("arst_m_tlast", 32'(m_tlast), 0);
    check_val("arst_intr", 32'(m_intr), 0);
    check_val("arst_ovf", 32'(ovf), 0);
    sb_q.delete();
    pkt_pos = 0;
    seq_exp = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    for (int i = 5; i <= 8; i++) send(DW'(i));
    wait_drain();
    repeat (10) @(posedge aclk);
    check_val("final_queue", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_pingpong_packetizer.md
Name: axis_pingpong_packetizer

Overview:
- Successor to the single-buffer AXI4-Stream packetizer between the ADC stream IP and the Microblaze stream port.
- Collects SMPLS samples into one of two packet banks, raises a timed interrupt, then drains the full bank to the master with a real AXI4-Stream handshake.
- Input keeps filling the other bank meanwhile, so the ADC stalls only when both banks are full.
- Adds a sticky overflow flag for ADC sources that ignore tready.

Parameters:
- DATA_WIDTH, 16, width of s/m tdata in bits (>=1)
- SMPLS, 30, samples per packet (>=2)
- INTR_CLKS, 32, interrupt pulse length in aclk cycles (>=1)

Ports:
- aclk  in  1  AXI clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  input sample valid
- s_axis_tdata  in  DATA_WIDTH  input sample
- s_axis_tready  out  1  high when the current write bank is not full
- m_axis_tvalid  out  1  output word valid
- m_axis_tdata  out  DATA_WIDTH  output word, registered
- m_axis_tlast  out  1  high on last word of packet
- m_axis_tready  in  1  master ready
- m_axis_interrupt  out  1  packet-ready pulse, INTR_CLKS cycles
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  synchronous clear for ovf

Behaviour:
- Reset (async, any time, including mid-packet):
  - Outputs: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_interrupt=0, ovf=0.
  - Internal state: both bank_full flags=0; wr_bank=rd_bank=0; wr_idx=rd_idx=0; interrupt counter=0; read FSM=IDLE.
  - Bank contents need not be cleared; partial packet is discarded.
- Storage: mem[2][SMPLS] of DATA_WIDTH. Index counters $clog2(SMPLS) bits, wrap SMPLS-1 -> 0.
- Write side:
  - s_axis_tready = ~bank_full[wr_bank], combinational from registers.
  - Accept on s_axis_tvalid & s_axis_tready: mem[wr_bank][wr_idx] <= s_axis_tdata; wr_idx++.
  - Accept with wr_idx==SMPLS-1: wr_idx<=0, bank_full[wr_bank]<=1, wr_bank toggles, interrupt counter loads INTR_CLKS.
- Interrupt:
  - m_axis_interrupt = (counter != 0), registered; rises the cycle after the last-sample accept.
  - Counter decrements to 0.
  - A new completion during a pulse reloads the counter; pulse extends, no gap.
- Read FSM states: IDLE, DATA.
  - IDLE: if bank_full[rd_bank], load m_axis_tdata <= mem[rd_bank][0], m_axis_tvalid<=1, m_axis_tlast<=(SMPLS==1 ? 1 : 0) [SMPLS>=2 so 0], go DATA.
  - DATA, handshake (tvalid & tready), rd_idx<SMPLS-1: rd_idx++, load next word; tlast=1 when the loaded index is SMPLS-1.
  - DATA, handshake on tlast word: m_axis_tvalid<=0, tlast<=0, rd_idx<=0, bank_full[rd_bank]<=0, rd_bank toggles, go IDLE.
  - DATA, no handshake: tdata/tlast/tvalid held stable (AXIS rule).
- Latency: last input accepted at cycle T gives bank_full=1 and interrupt=1 at T+1, m_axis_tvalid=1 at T+2 (if reader idle).
- Inter-packet gap: one idle cycle after tlast handshake before next packet's tvalid.
- Simultaneous fill/drain:
  - Writer never targets a full bank and reader only drains full banks, so set and clear never hit the same bank in one cycle.
  - Set of one bank and clear of the other in the same cycle are both honoured.
  - s_axis_tready re-asserts the cycle after the tlast handshake frees the bank.
- Overflow:
  - ovf <= 1 when s_axis_tvalid & ~s_axis_tready; that sample is dropped, not stored.
  - ovf_clr clears ovf next cycle; simultaneous set and clear: set wins.

Optional Feature:
- Macro: AXIS_PKT_HDR_EN
- Defined:
  - Each packet is preceded by one header word = packet sequence number (DATA_WIDTH bits, starts 0 at reset, increments per packet sent, wraps mod 2^DATA_WIDTH).
  - Read FSM gains HDR state between IDLE and DATA.
  - Packet is SMPLS+1 words; tlast only on the last data word.
  - Latency to first data word +1 cycle.
- Undefined: no header, SMPLS words per packet, no sequence counter logic.

Test Plan:
- SMPLS=4, INTR_CLKS=32, m_axis_tready=1, feed 1,2,3,4 back-to-back -> interrupt high 32 cycles from cycle after 4th accept; output 1,2,3,4 with tlast only on 4; tvalid first high 2 cycles after 4th accept.
- Same packet, m_axis_tready pattern 1,0,1,0 -> each word delivered exactly once in order; tdata/tlast stable while tvalid&~tready.
- m_axis_tready=0, feed 1..8 -> s_axis_tready=0 after 8th accept; 9th tvalid sets ovf=1, sample dropped. Release tready -> 1..4 then 5..8 (one idle cycle between); s_axis_tready=1 the cycle after tlast of first packet.
- Completion of packet 2 while interrupt counter =10 -> pulse reloads, interrupt continuous, ends 32 cycles after second completion.
- Assert aresetn=0 after 2 of 4 samples and mid-output -> all outputs at reset values immediately; then 5,6,7,8 -> output 5,6,7,8 only.
- ovf=1, ovf_clr pulse -> ovf=0 next cycle; ovf_clr in same cycle as new overflow -> ovf stays 1. With AXIS_PKT_HDR_EN: two packets -> header 0 then 1, 5 words each.
